// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: result = inp1 - inp2 - bin, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] inp1,
  input  logic [N-1:0] inp2,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic diff_bit(input logic a, input logic b, input logic bi);
    return a ^ b ^ bi;
  endfunction

  function automatic logic borrow_bit(input logic a, input logic b, input logic bi);
    return (~a & b) | (~(a ^ b) & bi);
  endfunction

  state_t         state_r;
  state_t         next_state_s;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic           borrow_r;
  logic [CW-1:0]  cnt_r;
  logic [N-1:0]   diff_r;
  logic           busy_r;
  logic           done_r;
  logic [N-1:0]   result_r;
  logic           bout_r;
  logic           accept_s;
  logic           last_s;
  logic           d_s;
  logic           nb_s;
  logic [N-1:0]   diff_next_s;
  logic           busy_s;
  logic           done_s;
`ifdef SERIAL_SUB_OVF_EN
  logic           a_msb_r;
  logic           b_msb_r;
  logic           ovf_r;
`endif

  // Current bit's difference/borrow and the handshake qualifiers
  always_comb begin
    accept_s    = start & ((state_r == IDLE) || (state_r == DONE));
    last_s      = (cnt_r == LAST);
    d_s         = diff_bit(a_r[0], b_r[0], borrow_r);
    nb_s        = borrow_bit(a_r[0], b_r[0], borrow_r);
    diff_next_s = {d_s, diff_r[N-1:1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; DONE accepts a new start exactly like IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      DONE: begin
        if (start) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so busy/done come straight off flops
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (next_state_s)
      IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      SHIFT: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand shift registers, borrow chain and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      diff_r   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
`endif
    end else if (accept_s) begin
      a_r      <= inp1;
      b_r      <= inp2;
      borrow_r <= bin;
      cnt_r    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_r  <= inp1[N-1];
      b_msb_r  <= inp2[N-1];
`endif
    end else if (state_r == SHIFT) begin
      a_r      <= {1'b0, a_r[N-1:1]};
      b_r      <= {1'b0, b_r[N-1:1]};
      borrow_r <= nb_s;
      diff_r   <= diff_next_s;
      // Hold on the last bit so the counter never wraps when N is a power of two
      cnt_r    <= last_s ? cnt_r : cnt_r + CW'(1);
    end
  end

  // Registered handshake and result; result/bout only move on SHIFT->DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      bout_r   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      if ((state_r == SHIFT) && last_s) begin
        result_r <= diff_next_s;
        bout_r   <= nb_s;
`ifdef SERIAL_SUB_OVF_EN
        ovf_r    <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_s);
`endif
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign bout   = bout_r;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_r;
`endif

endmodule
